// File: rtl/gate_vector_checker.sv
// ---------------------------------------------------------------------------
// gate_vector_checker
//
// Exercises an external 2-input logic gate with the four input vectors
// {a,b} = 00, 01, 10, 11 and compares its output against the function
// chosen by gate_sel when the run was started. After each vector is driven
// the block waits SETTLE_CYCLES idle cycles before sampling dut_out.
//
// Parameters
//   SETTLE_CYCLES  idle cycles between driving a vector and sampling (0..15)
//
// Optional feature (compile-time macro)
//   STOP_ON_FAIL_EN  when defined, the first mismatch ends the run at once
//                    (err_count=1, remaining vectors not driven)
//
// Ports
//   clk        in   rising-edge clock, sole clock
//   rst        in   synchronous active-high reset
//   start      in   run request, accepted only while busy=0
//   gate_sel   in   expected function: 0 AND, 1 OR, 2 NAND, 3 NOR,
//                   4 XOR, 5 XNOR, 6/7 invalid
//   dut_out    in   output of the gate under test
//   a, b       out  registered stimulus to the gate under test
//   busy       out  run in progress (DRIVE/SETTLE/SAMPLE)
//   done       out  one-cycle end-of-run pulse
//   pass       out  last run had zero mismatches, held until next start
//   err_count  out  mismatch count of the last run (0..4)
//   fail_vec   out  {a,b} of the first mismatching vector, 0 if none
// ---------------------------------------------------------------------------
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

`ifdef STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  // Last value of the settle counter; only meaningful when SETTLE_CYCLES > 0,
  // since SETTLE is never entered otherwise.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] gateSel_q, gateSel_d;
  logic [1:0] ab_q, ab_d;
  logic [3:0] settleCnt_q, settleCnt_d;
  logic [2:0] errCount_q, errCount_d;
  logic [1:0] failVec_q, failVec_d;
  logic       pass_q, pass_d;

  logic       accept;
  logic       gateValid;
  logic       mismatch;

  // Reference model of the expected gate; invalid selections never reach
  // SAMPLE, so they simply share the XNOR branch.
  function automatic logic expectedOut(input logic [2:0] sel,
                                       input logic va,
                                       input logic vb);
    case (sel)
      3'd0:    return va & vb;
      3'd1:    return va | vb;
      3'd2:    return ~(va & vb);
      3'd3:    return ~(va | vb);
      3'd4:    return va ^ vb;
      default: return ~(va ^ vb);
    endcase
  endfunction

  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign gateValid = (gate_sel < 3'd6);
  assign mismatch  = (dut_out != expectedOut(gateSel_q, ab_q[1], ab_q[0]));

  // State and datapath registers; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gateSel_q   <= 3'd0;
      ab_q        <= 2'b00;
      settleCnt_q <= 4'd0;
      errCount_q  <= 3'd0;
      failVec_q   <= 2'b00;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gateSel_q   <= gateSel_d;
      ab_q        <= ab_d;
      settleCnt_q <= settleCnt_d;
      errCount_q  <= errCount_d;
      failVec_q   <= failVec_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state logic. An invalid gate selection jumps straight to DONE so
  // no vectors are driven. In SAMPLE the run ends after vector 11, or early
  // on the first mismatch when the stop-on-fail build is selected.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = gateValid ? DRIVE : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (settleCnt_q == SettleLast) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if ((StopOnFail && mismatch) || (ab_q == 2'b11)) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The {a,b} register doubles as the vector index.
  // pass is resolved on the edge entering DONE from SAMPLE, using the count
  // that includes the vector being sampled on that same edge.
  always_comb begin
    gateSel_d   = gateSel_q;
    ab_d        = ab_q;
    errCount_d  = errCount_q;
    failVec_d   = failVec_q;
    pass_d      = pass_q;
    settleCnt_d = (state_q == SETTLE) ? settleCnt_q + 4'd1 : 4'd0;

    if (accept) begin
      gateSel_d  = gate_sel;
      errCount_d = 3'd0;
      failVec_d  = 2'b00;
      pass_d     = 1'b0;
      if (gateValid) begin
        ab_d = 2'b00;
      end
    end else if (state_q == SAMPLE) begin
      if (mismatch) begin
        errCount_d = errCount_q + 3'd1;
        if (errCount_q == 3'd0) begin
          failVec_d = ab_q;
        end
      end
      if (state_d == DRIVE) begin
        ab_d = ab_q + 2'd1;
      end else begin
        pass_d = (errCount_d == 3'd0);
      end
    end
  end

  // Output decode: status flags come straight from the state, results from
  // the registers.
  always_comb begin
    busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
    done      = (state_q == DONE);
    a         = ab_q[1];
    b         = ab_q[0];
    pass      = pass_q;
    err_count = errCount_q;
    fail_vec  = failVec_q;
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_vector_checker
//
// Bench for gate_vector_checker at the default SETTLE_CYCLES=2. A small gate
// model stands in for the device under test; its function and an optional
// stuck-at-0 vector are chosen per row of the vector table.
// ---------------------------------------------------------------------------
module tb_gate_vector_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  logic       dut_out;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;

  logic [2:0] dutFunc;
  logic       stuckEn;
  logic [1:0] stuckVec;
  logic [1:0] lastAb;

  int checks;
  int failures;

  typedef struct {
    logic [2:0] sel;
    logic [2:0] dutFunc;
    logic       stuckEn;
    logic [1:0] stuckVec;
    logic       expPass;
    logic [2:0] expErr;
    logic [1:0] expFail;
    int         expLat;
    logic [1:0] expAb;
  } vec_t;

  vec_t tbl[10];

  gate_vector_checker #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gate_sel  (gate_sel),
    .dut_out   (dut_out),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of the gate under test, with an optional stuck-at-0 on one vector.
  function automatic logic gateModel(input logic [2:0] f, input logic va, input logic vb);
    case (f)
      3'd0:    return va & vb;
      3'd1:    return va | vb;
      3'd2:    return ~(va & vb);
      3'd3:    return ~(va | vb);
      3'd4:    return va ^ vb;
      default: return ~(va ^ vb);
    endcase
  endfunction

  always_comb begin
    dut_out = gateModel(dutFunc, a, b);
    if (stuckEn && ({a, b} == stuckVec)) begin
      dut_out = 1'b0;
    end
  end

  function automatic vec_t mk(input logic [2:0] sel, input logic [2:0] f,
                              input logic se, input logic [1:0] sv,
                              input logic ep, input logic [2:0] ee,
                              input logic [1:0] ef, input int lat,
                              input logic [1:0] eab);
    vec_t v;
    v.sel = sel; v.dutFunc = f; v.stuckEn = se; v.stuckVec = sv;
    v.expPass = ep; v.expErr = ee; v.expFail = ef; v.expLat = lat; v.expAb = eab;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Start one run from the table and check latency, results and that the
  // done pulse lasts exactly one cycle with results held afterwards.
  task automatic applyStimulus(input int idx);
    vec_t v;
    int   n;
    logic [1:0] expAb;
    v        = tbl[idx];
    dutFunc  = v.dutFunc;
    stuckEn  = v.stuckEn;
    stuckVec = v.stuckVec;
    gate_sel = v.sel;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    gate_sel = ~v.sel;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    expAb = (v.sel >= 3'd6) ? lastAb : v.expAb;
    checkOutput($sformatf("row%0d latency", idx), n, v.expLat);
    checkOutput($sformatf("row%0d pass", idx), int'(pass), int'(v.expPass));
    checkOutput($sformatf("row%0d err_count", idx), int'(err_count), int'(v.expErr));
    checkOutput($sformatf("row%0d fail_vec", idx), int'(fail_vec), int'(v.expFail));
    checkOutput($sformatf("row%0d ab", idx), int'({a, b}), int'(expAb));
    checkOutput($sformatf("row%0d busy_in_done", idx), int'(busy), 0);
    lastAb = expAb;
    @(posedge clk);
    #1;
    checkOutput($sformatf("row%0d done_pulse", idx), int'(done), 0);
    checkOutput($sformatf("row%0d pass_held", idx), int'(pass), int'(v.expPass));
    checkOutput($sformatf("row%0d err_held", idx), int'(err_count), int'(v.expErr));
  endtask

  initial begin
    int n;
    int doneCnt;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    gate_sel = 3'd0;
    dutFunc  = 3'd2;
    stuckEn  = 1'b0;
    stuckVec = 2'b00;
    lastAb   = 2'b00;

    // sel, dutFunc, stuckEn, stuckVec, pass, err, fail, latency, final {a,b}
    tbl[0] = mk(3'd2, 3'd2, 1'b0, 2'b00, 1'b1, 3'd0, 2'b00, 16, 2'b11);
    tbl[1] = mk(3'd2, 3'd0, 1'b0, 2'b00, 1'b0, 3'd4, 2'b00, 16, 2'b11);
    tbl[2] = mk(3'd4, 3'd4, 1'b1, 2'b01, 1'b0, 3'd1, 2'b01, 16, 2'b11);
    tbl[3] = mk(3'd0, 3'd1, 1'b0, 2'b00, 1'b0, 3'd2, 2'b01, 16, 2'b11);
    tbl[4] = mk(3'd1, 3'd1, 1'b0, 2'b00, 1'b1, 3'd0, 2'b00, 16, 2'b11);
    tbl[5] = mk(3'd3, 3'd3, 1'b0, 2'b00, 1'b1, 3'd0, 2'b00, 16, 2'b11);
    tbl[6] = mk(3'd5, 3'd4, 1'b0, 2'b00, 1'b0, 3'd4, 2'b00, 16, 2'b11);
    tbl[7] = mk(3'd7, 3'd2, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00, 0,  2'b00);
    tbl[8] = mk(3'd6, 3'd2, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00, 0,  2'b00);
    tbl[9] = mk(3'd4, 3'd5, 1'b0, 2'b00, 1'b0, 3'd4, 2'b00, 16, 2'b11);
`ifdef STOP_ON_FAIL_EN
    tbl[1] = mk(3'd2, 3'd0, 1'b0, 2'b00, 1'b0, 3'd1, 2'b00, 4, 2'b00);
    tbl[2] = mk(3'd4, 3'd4, 1'b1, 2'b01, 1'b0, 3'd1, 2'b01, 8, 2'b01);
    tbl[3] = mk(3'd0, 3'd1, 1'b0, 2'b00, 1'b0, 3'd1, 2'b01, 8, 2'b01);
    tbl[6] = mk(3'd5, 3'd4, 1'b0, 2'b00, 1'b0, 3'd1, 2'b00, 4, 2'b00);
    tbl[9] = mk(3'd4, 3'd5, 1'b0, 2'b00, 1'b0, 3'd1, 2'b00, 4, 2'b00);
`endif

    // Reset state, with start held high to show reset takes priority.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset pass", int'(pass), 0);
    checkOutput("reset err_count", int'(err_count), 0);
    checkOutput("reset ab", int'({a, b}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle after reset busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(i);
    end

    // Start re-pulsed at edges 3 and 9 of a run must be ignored.
    dutFunc  = 3'd2;
    stuckEn  = 1'b0;
    gate_sel = 3'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n       = 0;
    doneCnt = 0;
    for (int e = 1; e <= 24; e++) begin
      start = (e == 3) || (e == 9);
      @(posedge clk);
      #1;
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) n = e;
      end
    end
    start = 1'b0;
    checkOutput("repulse done_count", doneCnt, 1);
    checkOutput("repulse latency", n, 16);
    checkOutput("repulse pass", int'(pass), 1);

    // Reset asserted at edge 7 of a run aborts it with no done.
    dutFunc  = 3'd0;
    gate_sel = 3'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("pre-abort busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort err_count", int'(err_count), 0);
    checkOutput("abort fail_vec", int'(fail_vec), 0);
    checkOutput("abort ab", int'({a, b}), 0);
    checkOutput("abort pass", int'(pass), 0);
    doneCnt = 0;
    for (int e = 0; e < 24; e++) begin
      @(posedge clk);
      #1;
      if (done || busy) doneCnt++;
    end
    checkOutput("abort quiet", doneCnt, 0);
    lastAb = 2'b00;

    // A normal run after the abort.
    applyStimulus(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
